// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready), synchronous flush and a saturating stall counter.
module pipe_stage_buf #(
    parameter int               WIDTH     = 32,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             main_v;
    logic             main_v_nxt;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_d_nxt;
    logic             skid_v;
    logic             acc;
    logic             pop;
    logic             stall;

    assign acc   = in_valid & in_ready;
    assign pop   = main_v & out_ready;
    assign stall = main_v & ~out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic             skid_v_nxt;
            logic [WIDTH-1:0] skid_d;
            logic [WIDTH-1:0] skid_d_nxt;
            logic             in_ready_q;

            // NOTE: every signal assigned in always_comb gets a default first,
            // so no path through the if/case tree can infer a latch.
            always_comb begin
                main_v_nxt = main_v;
                main_d_nxt = main_d;
                skid_v_nxt = skid_v;
                skid_d_nxt = skid_d;
                if (flush) begin
                    main_v_nxt = 1'b0;
                    main_d_nxt = RESET_VAL;
                    skid_v_nxt = 1'b0;
                    skid_d_nxt = RESET_VAL;
                end else if (skid_v) begin
                    // in_ready is low while full, so only a pop can happen here.
                    if (pop) begin
                        main_d_nxt = skid_d;
                        skid_v_nxt = 1'b0;
                        skid_d_nxt = RESET_VAL;
                    end
                end else if (main_v) begin
                    case ({acc, pop})
                        2'b11: main_d_nxt = in_data;
                        2'b10: begin
                            skid_v_nxt = 1'b1;
                            skid_d_nxt = in_data;
                        end
                        2'b01: begin
                            main_v_nxt = 1'b0;
                            main_d_nxt = RESET_VAL;
                        end
                        default: ;
                    endcase
                end else if (acc) begin
                    main_v_nxt = 1'b1;
                    main_d_nxt = in_data;
                end
            end

            // in_ready comes straight from a flop so the upstream timing path is cut.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    skid_v     <= 1'b0;
                    skid_d     <= RESET_VAL;
                    in_ready_q <= 1'b1;
                end else begin
                    skid_v     <= skid_v_nxt;
                    skid_d     <= skid_d_nxt;
                    in_ready_q <= ~skid_v_nxt;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_single
            assign skid_v   = 1'b0;
            assign in_ready = ~main_v | out_ready;

            always_comb begin
                main_v_nxt = main_v;
                main_d_nxt = main_d;
                if (flush) begin
                    main_v_nxt = 1'b0;
                    main_d_nxt = RESET_VAL;
                end else if (acc) begin
                    main_v_nxt = 1'b1;
                    main_d_nxt = in_data;
                end else if (pop) begin
                    main_v_nxt = 1'b0;
                    main_d_nxt = RESET_VAL;
                end
            end
        end
    endgenerate

    // NOTE: payload flops are reset too, because an empty entry must read as
    // RESET_VAL (a clean NOP bubble) rather than stale or unknown data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            main_v    <= 1'b0;
            main_d    <= RESET_VAL;
            stall_cnt <= '0;
        end else begin
            main_v <= main_v_nxt;
            main_d <= main_d_nxt;
            if (!flush && stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign out_valid = main_v;
    assign out_data  = main_d;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register for the mycpu pipeline.
- Generalises the fixed IF/ID/EX boundary registers into one block with:
  - arbitrary payload width;
  - valid/ready handshake instead of global stall wires;
  - an optional 2-entry skid buffer, so upstream ready is registered and timing is cut;
  - synchronous flush.
- Instantiated between every pair of stages, with the control/data bundle concatenated into one payload.

Parameters:
- WIDTH, 32: payload bits per entry (1..1024).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready.
- RESET_VAL, 0: payload value held when an entry is empty, after reset and after flush. Width is WIDTH.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- resetn, in, 1: reset, synchronous, active-low.
- flush, in, 1: synchronous squash of all held entries (branch/exception redirect).
- in_valid, in, 1: upstream stage offers in_data.
- in_ready, out, 1: block accepts in_data this cycle.
- in_data, in, WIDTH: upstream payload.
- out_valid, out, 1: out_data is a live instruction.
- out_ready, in, 1: downstream stage consumes out_data this cycle.
- out_data, out, WIDTH: payload presented downstream.
- occupancy, out, 2: number of held entries (0..2; max 1 when SKID=0).
- stall_cnt, out, CNT_W: saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Definitions:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
- State:
  - main entry (main_v, main_d);
  - skid entry (skid_v, skid_d), present only when SKID=1.
- Outputs:
  - out_valid = main_v.
  - out_data = main_d; main_d is forced to RESET_VAL whenever main_v=0, so a bubble is a cleared NOP.
  - occupancy = main_v + skid_v.
- Reset (resetn=0 at the edge):
  - main_v=skid_v=0; main_d=skid_d=RESET_VAL; stall_cnt=0.
  - Result: out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 in the following cycle.
  - Reset overrides flush and all handshakes, including mid-transfer.
- Flush (resetn=1, flush=1):
  - Same clearing as reset, except stall_cnt is held.
  - An input accepted in the flush cycle is discarded.
  - in_ready is not gated by flush.
- SKID=0:
  - in_ready = ~main_v | out_ready (combinational).
  - On acc: main_d<=in_data, main_v<=1.
  - On pop without acc: main_v<=0, main_d<=RESET_VAL.
  - Zero-bubble throughput: accept and pop may occur in the same cycle.
- SKID=1: in_ready = ~skid_v, driven from a flop. Next state, with a=acc and p=pop:
  - empty, a: main<=in.
  - main only, a & p: main<=in.
  - main only, a & ~p: skid<=in (becomes full; in_ready=0 next cycle).
  - main only, ~a & p: empty.
  - full, p (acc impossible when full): main<=skid; skid cleared to RESET_VAL.
  - full, ~p: hold both.
- Ordering: strict FIFO; an accepted payload appears on out_data exactly as accepted, never duplicated or dropped except by flush/reset.
- Latency: 1 cycle from acc to out_valid when empty. Steady-state throughput is 1 per cycle for both SKID settings.
- stall_cnt:
  - +1 each cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Downstream stall with upstream idle: state held unchanged. This replaces the old EX_stall hold.
- Upstream idle with downstream ready: entries drain and out_data returns to RESET_VAL. This replaces the old ID_stall bubble.
- X-safety: in_data is never sampled when in_valid=0.

Test Plan (each scenario run with WIDTH=32 and RESET_VAL=32'hbfc00000; "both" means run with SKID=0 and SKID=1):
- Reset: resetn=0 for 2 cycles with in_valid=1 and in_data=32'h1234 → out_valid=0, out_data=32'hbfc00000, occupancy=0, stall_cnt=0; in_ready=1 on the first cycle after release.
- Streaming (both): out_ready=1; push 32'h1, 32'h2, 32'h3 on consecutive cycles → out_data shows 1, 2, 3 on cycles 1, 2, 3 after each accept, no gaps, occupancy ≤1.
- Skid fill (SKID=1): out_ready=0; push A=32'hA0, B=32'hB0 → occupancy=2, in_ready=0, C held off, stall_cnt increments every cycle. Raise out_ready → pops A then B, in_ready=1 one cycle after the first pop.
- Flush: occupancy=2, flush=1 with in_valid=1 and in_data=32'hC0 in the same cycle → next cycle occupancy=0, out_valid=0, out_data=32'hbfc00000; 32'hC0 is never output; stall_cnt unchanged.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15 and holds; resetn=0 → 0.
- Random stress (both): random in_valid/out_ready/flush over 10k cycles vs scoreboard → FIFO order preserved; no loss except on flush; occupancy never exceeds 1+SKID.
